// File: rtl/seq_timing_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seq_timing_decoder
//  Description : Sequence counter feeding an N-to-2^N one-hot decoder that
//                produces the T0..Tn timing signals for the bus control unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_timing_decoder #(
    parameter int SEL_WIDTH  = 4,
    parameter int LAST_STATE = 2**SEL_WIDTH - 1,
    parameter int ONE_SHOT   = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      inr,
    input  logic                      clr,
    input  logic                      ld,
    input  logic [SEL_WIDTH-1:0]      ld_val,
    input  logic                      out_en,
    output logic [SEL_WIDTH-1:0]      count,
    output logic [(2**SEL_WIDTH)-1:0] t_out,
    output logic                      last,
    output logic                      wrap,
    output logic                      halted,
    output logic                      ld_err
);

    localparam int OUT_WIDTH = 2**SEL_WIDTH;
    localparam logic [SEL_WIDTH-1:0] c_last = SEL_WIDTH'(LAST_STATE);
    localparam logic [SEL_WIDTH-1:0] c_one  = SEL_WIDTH'(1);

    logic [SEL_WIDTH-1:0] r_count;
    logic                 r_wrap;
    logic                 r_halted;
    logic                 r_ld_err;

    logic                 w_at_last;
    logic                 w_ld_ok;

    assign w_at_last = (r_count == c_last);
    assign w_ld_ok   = (ld_val <= c_last);

    // Priority: rst > clr > ld > inr; pulse outputs default low each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= '0;
            r_wrap   <= 1'b0;
            r_halted <= 1'b0;
            r_ld_err <= 1'b0;
        end else begin
            r_wrap   <= 1'b0;
            r_ld_err <= 1'b0;
            if (clr) begin
                r_count  <= '0;
                r_halted <= 1'b0;
            end else if (ld) begin
                if (w_ld_ok) begin
                    r_count  <= ld_val;
                    r_halted <= 1'b0;
                end else begin
                    r_ld_err <= 1'b1;
                end
            end else if (inr) begin
                if (!w_at_last) begin
                    r_count <= r_count + c_one;
                end else if (ONE_SHOT == 0) begin
                    r_count <= '0;
                    r_wrap  <= 1'b1;
                end else begin
                    r_halted <= 1'b1;
                end
            end
        end
    end

    // Bits beyond the wrap point are tied low so they can never assert.
    for (genvar k = 0; k < OUT_WIDTH; k++) begin : g_dec
        if (k <= LAST_STATE) begin : g_live
            assign t_out[k] = out_en && (r_count == SEL_WIDTH'(k));
        end else begin : g_dead
            assign t_out[k] = 1'b0;
        end
    end

    assign count  = r_count;
    assign last   = w_at_last;
    assign wrap   = r_wrap;
    assign halted = r_halted;
    assign ld_err = r_ld_err;

endmodule
`default_nettype wire

// File: tb/tb_seq_timing_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_timing_decoder
//  Description : Directed self-checking bench for seq_timing_decoder across
//                free-run, one-shot, short-range and single-state builds.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_timing_decoder;

    logic       clk = 1'b0;
    logic       rst, inr, clr, ld, out_en;
    logic [2:0] ld_val;

    // a: 3-bit legacy, b: wrap at 5, c: one-shot at 5, d: single state
    logic [2:0] cnt_a, cnt_b, cnt_c, cnt_d;
    logic [7:0] t_a, t_b, t_c, t_d;
    logic       last_a, last_b, last_c, last_d;
    logic       wrap_a, wrap_b, wrap_c, wrap_d;
    logic       halt_a, halt_b, halt_c, halt_d;
    logic       lerr_a, lerr_b, lerr_c, lerr_d;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    seq_timing_decoder #(.SEL_WIDTH(3), .LAST_STATE(7), .ONE_SHOT(0)) dut_a (
        .clk(clk), .rst(rst), .inr(inr), .clr(clr), .ld(ld), .ld_val(ld_val),
        .out_en(out_en), .count(cnt_a), .t_out(t_a), .last(last_a),
        .wrap(wrap_a), .halted(halt_a), .ld_err(lerr_a));

    seq_timing_decoder #(.SEL_WIDTH(3), .LAST_STATE(5), .ONE_SHOT(0)) dut_b (
        .clk(clk), .rst(rst), .inr(inr), .clr(clr), .ld(ld), .ld_val(ld_val),
        .out_en(out_en), .count(cnt_b), .t_out(t_b), .last(last_b),
        .wrap(wrap_b), .halted(halt_b), .ld_err(lerr_b));

    seq_timing_decoder #(.SEL_WIDTH(3), .LAST_STATE(5), .ONE_SHOT(1)) dut_c (
        .clk(clk), .rst(rst), .inr(inr), .clr(clr), .ld(ld), .ld_val(ld_val),
        .out_en(out_en), .count(cnt_c), .t_out(t_c), .last(last_c),
        .wrap(wrap_c), .halted(halt_c), .ld_err(lerr_c));

    seq_timing_decoder #(.SEL_WIDTH(3), .LAST_STATE(0), .ONE_SHOT(0)) dut_d (
        .clk(clk), .rst(rst), .inr(inr), .clr(clr), .ld(ld), .ld_val(ld_val),
        .out_en(out_en), .count(cnt_d), .t_out(t_d), .last(last_d),
        .wrap(wrap_d), .halted(halt_d), .ld_err(lerr_d));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inr = 1'b0; clr = 1'b0; ld = 1'b0; ld_val = 3'd0;
    endtask

    task automatic do_reset();
        idle();
        out_en = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (cnt_a !== 3'd0 || t_a !== 8'h01) begin
            failed++;
            $display("FAIL reset_count_tout: count=%0d t_out=%h, want count=0 t_out=01", cnt_a, t_a);
        end
        tests++;
        if ({wrap_a, halt_a, lerr_a, last_a} !== 4'b0000) begin
            failed++;
            $display("FAIL reset_flags: wrap/halt/lderr/last=%b, want 0000", {wrap_a, halt_a, lerr_a, last_a});
        end
        tests++;
        if (last_d !== 1'b1 || t_d !== 8'h01) begin
            failed++;
            $display("FAIL reset_single_state: last=%b t_out=%h, want last=1 t_out=01", last_d, t_d);
        end
        out_en = 1'b0;
        #1;
        tests++;
        if (t_a !== 8'h00) begin
            failed++;
            $display("FAIL reset_gated: t_out=%h, want 00", t_a);
        end
        out_en = 1'b1;
    endtask

    task automatic test_free_run();
        int exp_cnt [7] = '{1, 2, 3, 4, 5, 0, 1};
        logic [7:0] exp_t;
        do_reset();
        inr = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            exp_t = 8'(1 << exp_cnt[i]);
            tests++;
            if (cnt_b !== 3'(exp_cnt[i]) || t_b !== exp_t) begin
                failed++;
                $display("FAIL free_run_step%0d: count=%0d t_out=%h, want count=%0d t_out=%h",
                         i, cnt_b, t_b, exp_cnt[i], exp_t);
            end
            tests++;
            if (last_b !== (exp_cnt[i] == 5) || wrap_b !== (i == 5)) begin
                failed++;
                $display("FAIL free_run_flags%0d: last=%b wrap=%b, want last=%b wrap=%b",
                         i, last_b, wrap_b, exp_cnt[i] == 5, i == 5);
            end
            tests++;
            if (cnt_d !== 3'd0 || wrap_d !== 1'b1 || t_d !== 8'h01) begin
                failed++;
                $display("FAIL single_state_wrap%0d: count=%0d wrap=%b t_out=%h, want 0 1 01",
                         i, cnt_d, wrap_d, t_d);
            end
        end
        inr = 1'b0;
        tick();
        tests++;
        if (wrap_d !== 1'b0 || cnt_b !== 3'd1) begin
            failed++;
            $display("FAIL free_run_idle: wrap_d=%b count_b=%0d, want wrap_d=0 count_b=1", wrap_d, cnt_b);
        end
    endtask

    task automatic test_legacy();
        logic [2:0] exp_c;
        do_reset();
        inr = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            exp_c = 3'(i % 8);
            tests++;
            if (cnt_a !== exp_c || t_a !== 8'(1 << (i % 8)) || wrap_a !== (i == 8)) begin
                failed++;
                $display("FAIL legacy_step%0d: count=%0d t_out=%h wrap=%b, want count=%0d t_out=%h wrap=%b",
                         i, cnt_a, t_a, wrap_a, exp_c, 8'(1 << (i % 8)), i == 8);
            end
        end
        idle();
    endtask

    task automatic test_one_shot();
        do_reset();
        inr = 1'b1;
        for (int i = 1; i <= 5; i++) tick();
        tests++;
        if (cnt_c !== 3'd5 || halt_c !== 1'b0) begin
            failed++;
            $display("FAIL one_shot_arrive: count=%0d halted=%b, want 5 0", cnt_c, halt_c);
        end
        for (int i = 6; i <= 8; i++) tick();
        tests++;
        if (cnt_c !== 3'd5 || t_c !== 8'h20 || halt_c !== 1'b1 || wrap_c !== 1'b0) begin
            failed++;
            $display("FAIL one_shot_hold: count=%0d t_out=%h halted=%b wrap=%b, want 5 20 1 0",
                     cnt_c, t_c, halt_c, wrap_c);
        end
        idle();
        ld = 1'b1; ld_val = 3'd2;
        tick();
        tests++;
        if (cnt_c !== 3'd2 || halt_c !== 1'b0) begin
            failed++;
            $display("FAIL one_shot_load: count=%0d halted=%b, want 2 0", cnt_c, halt_c);
        end
        idle();
        inr = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        idle();
        clr = 1'b1;
        tick();
        tests++;
        if (cnt_c !== 3'd0 || halt_c !== 1'b0 || t_c !== 8'h01) begin
            failed++;
            $display("FAIL one_shot_clr: count=%0d halted=%b t_out=%h, want 0 0 01", cnt_c, halt_c, t_c);
        end
        idle();
    endtask

    task automatic test_load_priority();
        do_reset();
        ld = 1'b1; ld_val = 3'd3;
        tick();
        tests++;
        if (cnt_b !== 3'd3 || lerr_b !== 1'b0) begin
            failed++;
            $display("FAIL load_ok: count=%0d ld_err=%b, want 3 0", cnt_b, lerr_b);
        end
        ld_val = 3'd6;
        tick();
        tests++;
        if (cnt_b !== 3'd3 || lerr_b !== 1'b1) begin
            failed++;
            $display("FAIL load_reject: count=%0d ld_err=%b, want 3 1", cnt_b, lerr_b);
        end
        idle();
        tick();
        tests++;
        if (cnt_b !== 3'd3 || lerr_b !== 1'b0) begin
            failed++;
            $display("FAIL load_err_pulse: count=%0d ld_err=%b, want 3 0", cnt_b, lerr_b);
        end
        ld = 1'b1; ld_val = 3'd5;
        tick();
        tests++;
        if (cnt_b !== 3'd5 || lerr_b !== 1'b0 || last_b !== 1'b1) begin
            failed++;
            $display("FAIL load_boundary: count=%0d ld_err=%b last=%b, want 5 0 1", cnt_b, lerr_b, last_b);
        end
        clr = 1'b1; ld = 1'b1; inr = 1'b1; ld_val = 3'd2;
        tick();
        tests++;
        if (cnt_b !== 3'd0) begin
            failed++;
            $display("FAIL prio_clr: count=%0d, want 0", cnt_b);
        end
        clr = 1'b0;
        tick();
        tests++;
        if (cnt_b !== 3'd2) begin
            failed++;
            $display("FAIL prio_ld_over_inr: count=%0d, want 2", cnt_b);
        end
        idle();
    endtask

    task automatic test_gating();
        do_reset();
        ld = 1'b1; ld_val = 3'd4;
        tick();
        idle();
        out_en = 1'b1;
        #1;
        tests++;
        if (t_b !== 8'h10) begin
            failed++;
            $display("FAIL gate_on: t_out=%h, want 10", t_b);
        end
        out_en = 1'b0;
        #1;
        tests++;
        if (t_b !== 8'h00 || cnt_b !== 3'd4) begin
            failed++;
            $display("FAIL gate_off: t_out=%h count=%0d, want 00 4", t_b, cnt_b);
        end
        out_en = 1'b1;
        #1;
        tests++;
        if (t_b !== 8'h10 || cnt_b !== 3'd4) begin
            failed++;
            $display("FAIL gate_back_on: t_out=%h count=%0d, want 10 4", t_b, cnt_b);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ld = 1'b1; ld_val = 3'd5;
        tick();
        idle();
        inr = 1'b1;
        tick();
        tick();
        tick();
        tick();
        tick();
        tests++;
        if (cnt_b !== 3'd4) begin
            failed++;
            $display("FAIL reset_mid_setup: count=%0d, want 4", cnt_b);
        end
        rst = 1'b1;
        tick();
        tests++;
        if (cnt_b !== 3'd0 || wrap_b !== 1'b0 || halt_b !== 1'b0 || t_b !== 8'h01) begin
            failed++;
            $display("FAIL reset_mid_abort: count=%0d wrap=%b halted=%b t_out=%h, want 0 0 0 01",
                     cnt_b, wrap_b, halt_b, t_b);
        end
        rst = 1'b0;
        tick();
        tests++;
        if (cnt_b !== 3'd1) begin
            failed++;
            $display("FAIL reset_mid_resume: count=%0d, want 1", cnt_b);
        end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        out_en = 1'b1;
        idle();
        test_reset();
        test_free_run();
        test_legacy();
        test_one_shot();
        test_load_priority();
        test_gating();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_timing_decoder.md
Name: seq_timing_decoder

Overview:
- Parametrised successor to the 3-to-8 combinational decoder.
- A SEL_WIDTH-bit sequence counter drives an N-to-2^N one-hot decoder, generating the T0..Tn timing signals for the common-bus control unit.
- Supports increment, synchronous clear, parallel load, programmable wrap point, and a free-run or one-shot mode.
- Sits between the control-logic gates and the instruction-cycle sequencing.

Parameters:
- SEL_WIDTH, 4: counter and select width. OUT_WIDTH = 2**SEL_WIDTH is derived locally and is not overridable.
- LAST_STATE, 2**SEL_WIDTH-1: terminal count. Must satisfy 0 <= LAST_STATE <= 2**SEL_WIDTH-1.
- ONE_SHOT, 0: 0 = wrap LAST_STATE->0. 1 = halt at LAST_STATE.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- inr  input  1  increment enable
- clr  input  1  synchronous clear of the counter to 0
- ld  input  1  parallel load strobe
- ld_val  input  SEL_WIDTH  value to load
- out_en  input  1  decoder output enable (combinational gate)
- count  output  SEL_WIDTH  registered counter value
- t_out  output  OUT_WIDTH  one-hot timing signals; bit k set when count==k and out_en=1
- last  output  1  combinational; high when count==LAST_STATE
- wrap  output  1  registered; one-cycle pulse after a LAST_STATE->0 wrap by increment
- halted  output  1  registered; ONE_SHOT only, set when an increment is requested at LAST_STATE
- ld_err  output  1  registered; one-cycle pulse when a load is rejected

Behaviour:
- Reset values: count=0, wrap=0, halted=0, ld_err=0.
  - t_out = 1 when out_en=1, else 0. last = (LAST_STATE==0).
- Command priority, evaluated per rising edge:
  1. rst
  2. clr
  3. ld
  4. inr
- Lower-priority commands in the same cycle are ignored.
- clr: count<=0, halted<=0. No wrap pulse.
- ld:
  - If ld_val<=LAST_STATE: count<=ld_val, halted<=0.
  - Else: count unchanged, halted unchanged, ld_err<=1 for one cycle.
- inr with count<LAST_STATE: count<=count+1.
- inr with count==LAST_STATE:
  - ONE_SHOT=0: count<=0, wrap<=1 next cycle.
  - ONE_SHOT=1: count holds, halted<=1. Further inr is ignored until clr or ld.
- No command: count holds.
- wrap and ld_err are single-cycle pulses and return to 0 unless re-triggered.
  - Back-to-back wraps are possible only when LAST_STATE==0; then wrap stays high for every increment cycle.
- t_out is decoded combinationally from registered count and gated by out_en.
  - Latency: one clock from a command to the new t_out bit.
  - out_en takes effect in the same cycle.
- Invariant: t_out is one-hot when out_en=1, zero otherwise. The bit set never exceeds LAST_STATE.
- Counter arithmetic is SEL_WIDTH unsigned with no silent overflow. The wrap point is LAST_STATE, not 2**SEL_WIDTH.
- rst mid-sequence aborts immediately. On the next edge all registered outputs return to their reset values.
- With SEL_WIDTH=3 and default LAST_STATE, t_out matches the legacy 3x8 decoding for count 0..7.

Test Plan:
- Reset, SEL_WIDTH=3, LAST_STATE=7, ONE_SHOT=0: hold rst 2 cycles, out_en=1 -> count=0, t_out=8'b00000001, wrap=0, halted=0, ld_err=0.
- Free-run wrap, LAST_STATE=5: inr=1 for 7 cycles -> count 1,2,3,4,5,0,1. t_out follows 0x02..0x20,0x01,0x02. last high at count=5. wrap=1 exactly the cycle count first reads 0.
- One-shot, ONE_SHOT=1, LAST_STATE=5: inr=1 for 8 cycles -> count sticks at 5, t_out=0x20, halted=1. Then clr -> count=0, halted=0, t_out=0x01.
- Load and priority, LAST_STATE=5:
  - ld=1, ld_val=3 -> count=3.
  - ld=1, ld_val=6 -> count stays 3, ld_err pulse 1 cycle.
  - clr=1, ld=1, inr=1 same cycle -> count=0.
  - ld=1, inr=1 with ld_val=2 -> count=2.
- Output gating: count=4, toggle out_en 1->0->1 -> t_out 0x10 -> 0x00 -> 0x10 in the same cycles. count is unaffected.
- Reset mid-run: rst at count=4 with inr=1 -> next edge count=0, wrap=0, halted=0. Counting resumes from 1 after rst drops.
